dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port 64-bit data RAM. It shares the RAM between the CPU load/store unit (port 0) and the program/data loader (port 1) using round-robin arbitration. It checks address range, turns byte-strobed stores into read-modify-write sequences, and returns one response per accepted request. It sits between the memory stage and the data RAM, and it is the RAM's only master.

---
 rtl/dmem_arbiter_pkg.sv | 26 ++
 rtl/dmem_arbiter_if.sv | 32 +++
 rtl/dmem_arbiter_rr_pick.sv | 40 ++++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types and helpers for the data-RAM arbiter.
//   state_t   : sequencer states (IDLE, RMW_WR)
//   NUM_PORTS : number of requesters sharing the RAM
//   BE_FULL   : byte-enable value that marks a full 64-bit store
//   merge()   : per-lane merge of store data into a RAM word
package dmem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    localparam int         NUM_PORTS = 2;
    localparam logic [7:0] BE_FULL   = 8'hFF;

    // Lane n takes the store byte when be[n] is set, otherwise keeps RAM data.
    function automatic logic [63:0] merge(input logic [63:0] rdata,
                                          input logic [63:0] wdata,
                                          input logic [7:0]  be);
        logic [63:0] m;
        for (int i = 0; i < 8; i++)
            m[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : rdata[i*8 +: 8];
        return m;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arb_if: requester-side bus of the data-RAM arbiter.
//   req_i/we_i/addr_i/wdata_i/be_i : per-port request and payload
//   gnt_o                          : per-port grant (one-hot or zero)
//   rvalid_o/rdata_o/err_o         : per-port response pulse, shared data/error
// Modports: master = requester side, slave = arbiter side.
interface dmem_arb_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 64
) ();

    logic [NUM_PORTS-1:0]             req_i;
    logic [NUM_PORTS-1:0]             we_i;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_i;
    logic [NUM_PORTS-1:0][63:0]       wdata_i;
    logic [NUM_PORTS-1:0][7:0]        be_i;
    logic [NUM_PORTS-1:0]             gnt_o;
    logic [NUM_PORTS-1:0]             rvalid_o;
    logic [63:0]                      rdata_o;
    logic                             err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// dmem_rr_pick: two-request round-robin picker.
//   clk_i, rst_n_i : clock, async active-low reset
//   i_en           : picking allowed this cycle
//   i_req          : per-port requests
//   o_gnt          : one-hot grant (zero when disabled or idle)
// The pointer remembers the last winner; reset leaves it on port 1 so
// port 0 wins the first contended cycle.
module dmem_rr_pick (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic       r_last;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign o_gnt = w_gnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_last <= 1'b1;
        else if (i_en && (|i_req))
            r_last <= w_gnt[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 64-bit data RAM between the
// load/store unit (port 0) and the loader (port 1).
//   clk_i, rst_n_i : clock, async active-low reset
//   bus            : dmem_arb_if.slave requester bus (req/gnt/response)
//   mem_addr_o, mem_wdata_o, mem_wen_o : RAM command
//   mem_rdata_i    : RAM combinational read data
// Optional feature macro DMEM_ARB_RMW_EN: partial stores become a
// read-merge-write pair (IDLE -> RMW_WR). Without it be_i is ignored and
// every store is a full single-cycle write.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_BYTES = 5000,
    parameter int ADDR_W    = 64
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    dmem_arb_if.slave         bus,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [63:0]       mem_wdata_o,
    output logic              mem_wen_o,
    input  logic [63:0]       mem_rdata_i
);

    // addr + 7 < MEM_BYTES, written to avoid wrap near the top of the space
    localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(MEM_BYTES - 7);

    state_t                w_state;
    logic [NUM_PORTS-1:0]  w_gnt;
    logic                  w_any;
    logic                  w_port;
    logic [ADDR_W-1:0]     w_addr;
    logic [63:0]           w_wdata;
    logic                  w_we;
    logic                  w_in_range;
    logic                  w_partial;
    logic [NUM_PORTS-1:0]  r_rvalid;
    logic [63:0]           r_rdata;
    logic                  r_err;

    dmem_rr_pick u_pick (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_en    (w_state == IDLE),
        .i_req   (bus.req_i),
        .o_gnt   (w_gnt)
    );

    assign w_any      = |w_gnt;
    assign w_port     = w_gnt[1];
    assign w_addr     = bus.addr_i[w_port];
    assign w_wdata    = bus.wdata_i[w_port];
    assign w_we       = bus.we_i[w_port];
    assign w_in_range = (w_addr < ADDR_LIM);

`ifdef DMEM_ARB_RMW_EN
    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_merge;
    logic              r_port;

    assign w_partial = w_we && w_in_range && (bus.be_i[w_port] != BE_FULL);
    assign w_state   = r_state;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any && w_partial) w_next_state = RMW_WR;
            RMW_WR:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Capture the merged word while the RAM read for the grant is on the bus.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr  <= '0;
            r_merge <= '0;
            r_port  <= 1'b0;
        end else if (r_state == IDLE && w_any && w_partial) begin
            r_addr  <= w_addr;
            r_merge <= merge(mem_rdata_i, w_wdata, bus.be_i[w_port]);
            r_port  <= w_port;
        end
    end
`else
    logic w_unused;
    assign w_unused  = ^bus.be_i;
    assign w_partial = 1'b0;
    assign w_state   = IDLE;
`endif

    // FSM outputs: grant and RAM command
    always_comb begin
        bus.gnt_o   = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wen_o   = 1'b0;
        case (w_state)
            IDLE: begin
                bus.gnt_o = w_gnt;
                if (w_any) begin
                    mem_addr_o = w_addr;
                    if (w_we && w_in_range && !w_partial) begin
                        mem_wen_o   = 1'b1;
                        mem_wdata_o = w_wdata;
                    end
                end
            end
`ifdef DMEM_ARB_RMW_EN
            RMW_WR: begin
                mem_addr_o  = r_addr;
                mem_wdata_o = r_merge;
                mem_wen_o   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Response: one pulse per accepted request; data only for in-range reads.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
`ifdef DMEM_ARB_RMW_EN
            if (r_state == RMW_WR)
                r_rvalid <= r_port ? 2'b10 : 2'b01;
            else
`endif
            if (w_any && !w_partial) begin
                r_rvalid <= w_gnt;
                if (!w_in_range) r_err   <= 1'b1;
                else if (!w_we)  r_rdata <= mem_rdata_i;
            end
        end
    end

    assign bus.rvalid_o = r_rvalid;
    assign bus.rdata_o  = r_rdata;
    assign bus.err_o    = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM. Requests push
// their expected response into a queue; a monitor pops and compares on
// every rvalid_o pulse, including the expected response cycle.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

`ifdef DMEM_ARB_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    typedef struct {
        int          port;
        logic [63:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_wen_o;
    logic [63:0] mem_rdata_i;

    logic [63:0] mem [0:624];
    logic        pl_en = 1'b0;
    int          pl_idx = 0;
    logic [63:0] pl_data = '0;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t q[$];

    dmem_arb_if #(.ADDR_W(64)) bus ();

    dmem_arbiter #(.MEM_BYTES(5000), .ADDR_W(64)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .bus         (bus),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wen_o   (mem_wen_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural RAM: combinational read, write on the clock edge.
    assign mem_rdata_i = (mem_addr_o[63:3] < 61'd625) ? mem[mem_addr_o[12:3]] : 64'h0;
    always @(posedge clk_i) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_wen_o && mem_addr_o[63:3] < 61'd625) mem[mem_addr_o[12:3]] <= mem_wdata_o;
    end

    function automatic logic [1:0] onehot(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk_i) begin
        if (rst_n_i && bus.rvalid_o != 2'b00) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_rvalid: got rvalid=%b at cycle %0d expected none", bus.rvalid_o, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_port",  64'(bus.rvalid_o), 64'(onehot(e.port)));
                chk("rsp_rdata", bus.rdata_o, e.rdata);
                chk("rsp_err",   64'(bus.err_o), 64'(e.err));
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic preload(input int idx, input logic [63:0] d);
        @(posedge clk_i); #1;
        pl_en = 1'b1; pl_idx = idx; pl_data = d;
        @(posedge clk_i); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
    endtask

    // One request; checks grant-cycle and following-cycle RAM command.
    task automatic do_req(input int p, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] be,
                          input logic [63:0] exp_rdata, input logic exp_err,
                          input int lat, input logic wen_t0, input logic wen_t1);
        bit got = 0;
        @(posedge clk_i); #1;
        bus.req_i[p] = 1'b1; bus.we_i[p] = we; bus.addr_i[p] = addr;
        bus.wdata_i[p] = wdata; bus.be_i[p] = be;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (bus.gnt_o[p]) begin got = 1; break; end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL grant_timeout: port %0d got no grant within 20 cycles", p);
            bus.req_i[p] = 1'b0;
            return;
        end
        chk("gnt",      64'(bus.gnt_o), 64'(onehot(p)));
        chk("mem_addr", mem_addr_o, addr);
        chk("wen_t0",   64'(mem_wen_o), 64'(wen_t0));
        if (wen_t0) chk("wdata_t0", mem_wdata_o, wdata);
        q.push_back('{p, exp_rdata, exp_err, cyc + lat});
        @(posedge clk_i); #1;
        bus.req_i[p] = 1'b0;
        @(negedge clk_i);
        chk("wen_t1", 64'(mem_wen_o), 64'(wen_t1));
        if (wen_t1) chk("mem_addr_t1", mem_addr_o, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0;
        #3 rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_gnt",    64'(bus.gnt_o), 64'h0);
        chk("rst_rvalid", 64'(bus.rvalid_o), 64'h0);
        chk("rst_rdata",  bus.rdata_o, 64'h0);
        chk("rst_err",    64'(bus.err_o), 64'h0);
        chk("rst_wen",    64'(mem_wen_o), 64'h0);
        chk("rst_maddr",  mem_addr_o, 64'h0);
        chk("rst_mwdata", mem_wdata_o, 64'h0);
        @(posedge clk_i); #1 rst_n_i = 1'b1;

        preload(64'h12C8 >> 3, 64'h00000032FFFFFFFF);
        preload(64'h0100 >> 3, 64'hAAAA0000AAAA0000);
        preload(64'h0108 >> 3, 64'hBBBB1111BBBB1111);
        preload(64'h12D0 >> 3, 64'h0000005A0000000A);
        preload(64'h12D8 >> 3, 64'hFFFFFFFFFFFFFFFF);
        preload(64'h12E0 >> 3, 64'h0123456789ABCDEF);
        preload(624,           64'hCAFEF00D12345678);

        // First read after reset
        do_req(0, 1'b0, 64'h12C8, 64'h0, 8'hFF, 64'h00000032FFFFFFFF, 1'b0, 1, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        chk("idle_gnt",  64'(bus.gnt_o), 64'h0);
        chk("idle_addr", mem_addr_o, 64'h0);

        // Contended back-to-back reads alternate starting at port 0
        do_reset();
        @(posedge clk_i); #1;
        bus.req_i = 2'b11; bus.we_i = 2'b00;
        bus.addr_i[0] = 64'h0100; bus.addr_i[1] = 64'h0108;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            chk("rr_gnt", 64'(bus.gnt_o), 64'(onehot(k % 2)));
            q.push_back('{k % 2, (k % 2) ? 64'hBBBB1111BBBB1111 : 64'hAAAA0000AAAA0000, 1'b0, cyc + 1});
        end
        @(posedge clk_i); #1 bus.req_i = 2'b00;
        repeat (2) @(posedge clk_i);

        // Partial store 0x0F from port 1, then readback by port 0
        do_req(1, 1'b1, 64'h12D0, 64'h1122334455667788, 8'h0F, 64'h0, 1'b0,
               RMW ? 2 : 1, !RMW, RMW);
        do_req(0, 1'b0, 64'h12D0, 64'h0, 8'hFF,
               RMW ? 64'h0000005A55667788 : 64'h1122334455667788, 1'b0, 1, 1'b0, 1'b0);

        // be=01 store of 0xAB
        do_req(0, 1'b1, 64'h12D8, 64'h00000000000000AB, 8'h01, 64'h0, 1'b0,
               RMW ? 2 : 1, !RMW, RMW);
        do_req(1, 1'b0, 64'h12D8, 64'h0, 8'hFF,
               RMW ? 64'hFFFFFFFFFFFFFFAB : 64'h00000000000000AB, 1'b0, 1, 1'b0, 1'b0);

        // be=0 store
        do_req(1, 1'b1, 64'h12E0, 64'hDEADBEEFDEADBEEF, 8'h00, 64'h0, 1'b0,
               RMW ? 2 : 1, !RMW, RMW);
        do_req(0, 1'b0, 64'h12E0, 64'h0, 8'hFF,
               RMW ? 64'h0123456789ABCDEF : 64'hDEADBEEFDEADBEEF, 1'b0, 1, 1'b0, 1'b0);

        // Range boundary
        do_req(0, 1'b0, 64'd4993, 64'h0, 8'hFF, 64'h0, 1'b1, 1, 1'b0, 1'b0);
        do_req(0, 1'b1, 64'd4993, 64'h5555555555555555, 8'hFF, 64'h0, 1'b1, 1, 1'b0, 1'b0);
        do_req(1, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h5555555555555555, 8'hFF, 64'h0, 1'b1, 1, 1'b0, 1'b0);
        do_req(0, 1'b0, 64'd4992, 64'h0, 8'hFF, 64'hCAFEF00D12345678, 1'b0, 1, 1'b0, 1'b0);

        // Full store by port 0, read back by port 1
        do_req(0, 1'b1, 64'h0200, 64'h0F0E0D0C0B0A0908, 8'hFF, 64'h0, 1'b0, 1, 1'b1, 1'b0);
        do_req(1, 1'b0, 64'h0200, 64'h0, 8'hFF, 64'h0F0E0D0C0B0A0908, 1'b0, 1, 1'b0, 1'b0);

`ifdef DMEM_ARB_RMW_EN
        // Reset during RMW_WR: write aborted, no response, pointer back to port 0
        begin
            logic [63:0] before;
            before = mem[64'h0108 >> 3];
            @(posedge clk_i); #1;
            bus.req_i[1] = 1'b1; bus.we_i[1] = 1'b1; bus.addr_i[1] = 64'h0108;
            bus.wdata_i[1] = 64'h9999999999999999; bus.be_i[1] = 8'h0F;
            @(negedge clk_i);
            chk("rmwrst_gnt", 64'(bus.gnt_o), 64'h2);
            @(posedge clk_i); #1;
            bus.req_i = 2'b00;
            chk("rmwrst_wen_on", 64'(mem_wen_o), 64'h1);
            rst_n_i = 1'b0;
            #1;
            chk("rmwrst_wen_off", 64'(mem_wen_o), 64'h0);
            repeat (2) @(posedge clk_i);
            #1 rst_n_i = 1'b1;
            chk("rmwrst_mem", mem[64'h0108 >> 3], before);
            bus.req_i = 2'b11; bus.we_i = 2'b00;
            bus.addr_i[0] = 64'h0100; bus.addr_i[1] = 64'h0108;
            @(negedge clk_i);
            chk("rmwrst_next_gnt", 64'(bus.gnt_o), 64'h1);
            q.push_back('{0, 64'hAAAA0000AAAA0000, 1'b0, cyc + 1});
            @(posedge clk_i); #1 bus.req_i = 2'b00;
        end
`endif

        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
